// File: rtl/proc_io_pkg.sv
// Shared helpers for the processor I/O hub: clog2, float word width and
// address port width.
package proc_io_pkg;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (n > (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

  // Float word width: sign + exponent + mantissa.
  function automatic int unsigned fw(input int unsigned man, input int unsigned exp);
    return man + exp + 1;
  endfunction

  // Address port width, never below one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/float2int.sv
// Processor float to signed integer, truncating toward zero and saturating
// to +/-(2**(OWID-1)-1) when out of range. Combinational.
// Ports: din (MAN+EXP+1 float), dout (OWID signed).
module float2int #(
    parameter int unsigned MAN  = 19,
    parameter int unsigned EXP  = 8,
    parameter int unsigned OWID = 28
  ) (
    input  logic [MAN+EXP:0] din,
    output logic [OWID-1:0]  dout
  );

  localparam int          BIAS = (1 << (EXP - 1)) - 1;
  localparam int unsigned SW   = OWID + MAN + 1;

  logic            sgn;
  logic [EXP-1:0]  e;
  logic [MAN-1:0]  m;
  int              ue;
  logic [OWID-1:0] mag;

  always_comb begin
    {sgn, e, m} = din;
    ue  = int'(e) - BIAS;
    mag = '0;
    if (ue >= int'(OWID) - 1) mag = {1'b0, {(OWID-1){1'b1}}};
    else if (ue >= 0)         mag = OWID'((SW'({1'b1, m}) << ue) >> MAN);
    dout = sgn ? (~mag + OWID'(1)) : mag;
  end

endmodule

// File: rtl/int2float.sv
// Signed integer to processor float {sign, biased exponent, mantissa with
// hidden leading one}. Zero maps to the all-zero word. Combinational.
// Ports: din (IWID signed), dout (MAN+EXP+1 float).
module int2float #(
    parameter int unsigned IWID = 19,
    parameter int unsigned MAN  = 19,
    parameter int unsigned EXP  = 8
  ) (
    input  logic [IWID-1:0]  din,
    output logic [MAN+EXP:0] dout
  );

  localparam int unsigned BIAS = (1 << (EXP - 1)) - 1;

  logic              sgn;
  logic [IWID-1:0]   mag;
  logic [MAN-1:0]    mant;
  int unsigned       msb;

  always_comb begin
    sgn = din[IWID-1];
    mag = sgn ? (~din + IWID'(1)) : din;
    msb = 0;
    for (int unsigned i = 0; i < IWID; i++) begin
      if (mag[i]) msb = i;
    end
    // Shift the leading one out of the top, keep the next MAN bits.
    mant = MAN'(({mag, MAN'(0)} << (IWID - msb)) >> IWID);
    if (mag == '0) dout = '0;
    else           dout = {sgn, EXP'(BIAS + msb), mant};
  end

endmodule

// File: rtl/io_fifo.sv
// Single-channel synchronous FIFO of float words. The caller only pushes
// when !full and only pops when !empty; head is the oldest entry.
// Ports: clk, rst (async high), push, pop, din, head, full, empty.
module io_fifo import proc_io_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 28
  ) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
  );

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Pointers wrap naturally; count alone decides full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/proc_io_hub.sv
// I/O front end for the float soft processor: NIN buffered integer input
// channels (converted to float on push) and NOUT registered integer output
// channels (converted from float on load), each with valid/ready. Reads of
// an empty channel or writes to a busy one stall the processor; accesses to
// nonexistent channels never stall and set the sticky addr_err.
// Ports: clk, rst (async high); in_data/in_valid/in_ready;
// out_data/out_valid/out_ready; proc_addr_in/proc_req_in/proc_din;
// proc_addr_out/proc_out_en/proc_dout; proc_stall; addr_err.
// Build option PROC_IO_HUB_STATS_EN adds stall_cnt, a saturating count of
// stalled cycles.
module proc_io_hub import proc_io_pkg::*; #(
    parameter int unsigned MAN   = 19,
    parameter int unsigned EXP   = 8,
    parameter int unsigned IWID  = 19,
    parameter int unsigned OWID  = 28,
    parameter int unsigned NIN   = 4,
    parameter int unsigned NOUT  = 4,
    parameter int unsigned DEPTH = 4
  ) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NIN*IWID-1:0]          in_data,
    input  logic [NIN-1:0]               in_valid,
    output logic [NIN-1:0]               in_ready,
    output logic [NOUT*OWID-1:0]         out_data,
    output logic [NOUT-1:0]              out_valid,
    input  logic [NOUT-1:0]              out_ready,
    input  logic [addr_w(NIN)-1:0]       proc_addr_in,
    input  logic                         proc_req_in,
    output logic [fw(MAN, EXP)-1:0]      proc_din,
    input  logic [addr_w(NOUT)-1:0]      proc_addr_out,
    input  logic                         proc_out_en,
    input  logic [fw(MAN, EXP)-1:0]      proc_dout,
    output logic                         proc_stall,
    output logic                         addr_err
`ifdef PROC_IO_HUB_STATS_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
  );

  localparam int unsigned FW  = fw(MAN, EXP);
  localparam int unsigned AIW = addr_w(NIN);
  localparam int unsigned AOW = addr_w(NOUT);

  logic [NIN-1:0]  full, empty, push, pop;
  logic [FW-1:0]   in_float [NIN];
  logic [FW-1:0]   head     [NIN];
  logic [OWID-1:0] out_int;
  logic            rd_hit, rd_empty, wr_hit, wr_busy, rd_go, wr_go;
  logic [FW-1:0]   rd_head;

  // Input channels: convert at push time, buffer floats.
  for (genvar k = 0; k < NIN; k++) begin : g_in
    int2float #(.IWID(IWID), .MAN(MAN), .EXP(EXP)) u_i2f (
      .din  (in_data[k*IWID +: IWID]),
      .dout (in_float[k])
    );
    assign push[k] = in_valid[k] & ~full[k];
    assign pop[k]  = rd_go & (proc_addr_in == AIW'(k));
    io_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (in_float[k]),
      .head  (head[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  assign in_ready = ~full;

  // Every output register loads the same converted word, so one converter.
  float2int #(.MAN(MAN), .EXP(EXP), .OWID(OWID)) u_f2i (
    .din  (proc_dout),
    .dout (out_int)
  );

  // Channel select; addresses past the channel count leave *_hit low.
  always_comb begin
    rd_hit   = 1'b0;
    rd_empty = 1'b0;
    rd_head  = '0;
    wr_hit   = 1'b0;
    wr_busy  = 1'b0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (proc_addr_in == AIW'(k)) begin
        rd_hit   = 1'b1;
        rd_empty = empty[k];
        rd_head  = head[k];
      end
    end
    for (int unsigned k = 0; k < NOUT; k++) begin
      if (proc_addr_out == AOW'(k)) begin
        wr_hit  = 1'b1;
        wr_busy = out_valid[k] & ~out_ready[k];
      end
    end
  end

  // Either side stalling blocks both, so a request never half-commits.
  assign proc_stall = (proc_req_in & rd_hit & rd_empty) |
                      (proc_out_en & wr_hit & wr_busy);
  assign rd_go      = proc_req_in & rd_hit & ~proc_stall;
  assign wr_go      = proc_out_en & wr_hit & ~proc_stall;
  assign proc_din   = (proc_req_in & rd_hit & ~rd_empty) ? rd_head : '0;

  // Output holding registers: a reload wins over a same-cycle drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        if (wr_go && (proc_addr_out == AOW'(k))) begin
          out_data[k*OWID +: OWID] <= out_int;
          out_valid[k]             <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Sticky flag for any access to a nonexistent channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  addr_err <= 1'b0;
    else if ((proc_req_in & ~rd_hit) | (proc_out_en & ~wr_hit)) addr_err <= 1'b1;
  end

`ifdef PROC_IO_HUB_STATS_EN
  // Saturating stalled-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 stall_cnt <= '0;
    else if (proc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_proc_io_hub.sv
// Self-checking bench for proc_io_hub: a 4x4 instance for the data paths and
// a 3x3 instance for out-of-range addressing.
module tb_proc_io_hub;

  localparam int unsigned FW = 28;
  localparam int unsigned IW = 19;
  localparam int unsigned OW = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4*IW-1:0] in_data  = '0;
  logic [3:0]      in_valid = '0;
  logic [3:0]      in_ready;
  logic [4*OW-1:0] out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready = 4'hF;
  logic [1:0]      proc_addr_in = '0, proc_addr_out = '0;
  logic            proc_req_in = 1'b0, proc_out_en = 1'b0;
  logic [FW-1:0]   proc_din;
  logic [FW-1:0]   proc_dout = '0;
  logic            proc_stall, addr_err;

  logic [3*IW-1:0] in_data3  = '0;
  logic [2:0]      in_valid3 = '0;
  logic [2:0]      in_ready3;
  logic [3*OW-1:0] out_data3;
  logic [2:0]      out_valid3;
  logic [2:0]      out_ready3 = 3'h7;
  logic [1:0]      addr_in3 = '0, addr_out3 = '0;
  logic            req3 = 1'b0, out_en3 = 1'b0;
  logic [FW-1:0]   din3;
  logic [FW-1:0]   dout3 = '0;
  logic            stall3, addr_err3;

`ifdef PROC_IO_HUB_STATS_EN
  logic [31:0] stall_cnt, stall_cnt3;
`endif

  proc_io_hub dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .proc_addr_in(proc_addr_in), .proc_req_in(proc_req_in), .proc_din(proc_din),
    .proc_addr_out(proc_addr_out), .proc_out_en(proc_out_en), .proc_dout(proc_dout),
    .proc_stall(proc_stall), .addr_err(addr_err)
`ifdef PROC_IO_HUB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  proc_io_hub #(.NIN(3), .NOUT(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .proc_addr_in(addr_in3), .proc_req_in(req3), .proc_din(din3),
    .proc_addr_out(addr_out3), .proc_out_en(out_en3), .proc_dout(dout3),
    .proc_stall(stall3), .addr_err(addr_err3)
`ifdef PROC_IO_HUB_STATS_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;

  // Scoreboards: floats expected on reads, integers expected on outputs.
  logic [FW-1:0] rd_q  [4][$];
  int            out_q [4][$];

  // Reference encoding: normalise the magnitude until bit 18 is set.
  function automatic logic [FW-1:0] fbits(input int v);
    logic [18:0] mm;
    int          e;
    logic        s;
    if (v == 0) return '0;
    s  = (v < 0);
    mm = 19'(s ? -v : v);
    e  = 18;
    while (mm[18] == 1'b0) begin
      mm = mm << 1;
      e--;
    end
    return {s, 8'(127 + e), mm[17:0], 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready got %b want 1111", in_ready); end
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (proc_stall !== 1'b0 || proc_din !== '0) begin errors++; $display("FAIL reset_proc got stall=%b din=%h want 0/0", proc_stall, proc_din); end
    checks++; if (addr_err !== 1'b0 || addr_err3 !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b/%b want 0/0", addr_err, addr_err3); end
    checks++; if (in_ready3 !== 3'b111) begin errors++; $display("FAIL reset_in_ready3 got %b want 111", in_ready3); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    int            vals [2] = '{5, -7};
    logic [FW-1:0] exp_f, cap;
    int            exp_i;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_data[0 +: IW] = IW'(vals[i]);
      in_valid[0] = 1'b1;
      rd_q[0].push_back(fbits(vals[i]));
      @(negedge clk);
      in_valid[0] = 1'b0;
      proc_req_in = 1'b1; proc_addr_in = 2'd0;
      #1;
      exp_f = rd_q[0].pop_front();
      checks++; if (proc_stall !== 1'b0 || proc_din !== exp_f) begin errors++; $display("FAIL loopback_read got stall=%b din=%h want 0/%h", proc_stall, proc_din, exp_f); end
      cap = proc_din;
      @(negedge clk);
      proc_req_in = 1'b0;
      proc_out_en = 1'b1; proc_addr_out = 2'd2; proc_dout = cap;
      out_q[2].push_back(vals[i]);
      @(negedge clk);
      proc_out_en = 1'b0;
      #1;
      exp_i = out_q[2].pop_front();
      checks++; if (out_valid[2] !== 1'b1 || out_data[2*OW +: OW] !== OW'(exp_i)) begin errors++; $display("FAIL loopback_out got v=%b d=%h want 1/%h", out_valid[2], out_data[2*OW +: OW], OW'(exp_i)); end
    end
  endtask

  task automatic test_fill();
    logic [FW-1:0] exp_f;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_data[IW +: IW] = IW'(10 + i); in_valid[1] = 1'b1;
      rd_q[1].push_back(fbits(10 + i));
      #1;
      checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", i, in_ready[1]); end
    end
    // Full: the 99 push is refused while a pop drains one slot.
    @(negedge clk);
    in_data[IW +: IW] = IW'(99);
    proc_req_in = 1'b1; proc_addr_in = 2'd1;
    #1;
    exp_f = rd_q[1].pop_front();
    checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL fill_full got %b want 0", in_ready[1]); end
    checks++; if (proc_stall !== 1'b0 || proc_din !== exp_f) begin errors++; $display("FAIL fill_pop_full got %b/%h want 0/%h", proc_stall, proc_din, exp_f); end
    // Simultaneous push and pop at count 3.
    @(negedge clk);
    in_data[IW +: IW] = IW'(14);
    rd_q[1].push_back(fbits(14));
    #1;
    exp_f = rd_q[1].pop_front();
    checks++; if (in_ready[1] !== 1'b1 || proc_din !== exp_f) begin errors++; $display("FAIL fill_pushpop got rdy=%b din=%h want 1/%h", in_ready[1], proc_din, exp_f); end
    @(negedge clk);
    proc_req_in = 1'b0;
    in_data[IW +: IW] = IW'(15);
    rd_q[1].push_back(fbits(15));
    #1;
    checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL fill_count_kept got %b want 1", in_ready[1]); end
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL fill_refull got %b want 0", in_ready[1]); end
    // Drain across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      proc_req_in = 1'b1; proc_addr_in = 2'd1;
      #1;
      exp_f = rd_q[1].pop_front();
      checks++; if (proc_stall !== 1'b0 || proc_din !== exp_f) begin errors++; $display("FAIL fill_drain_%0d got %b/%h want 0/%h", i, proc_stall, proc_din, exp_f); end
    end
    @(negedge clk);
    proc_req_in = 1'b0;
    #1;
    checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL fill_empty_ready got %b want 1", in_ready[1]); end
  endtask

  task automatic test_empty_stall();
    logic [FW-1:0] exp_f;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      proc_req_in = 1'b1; proc_addr_in = 2'd3;
      #1;
      exp_stalls++;
      checks++; if (proc_stall !== 1'b1 || proc_din !== '0) begin errors++; $display("FAIL empty_stall_%0d got %b/%h want 1/0", i, proc_stall, proc_din); end
    end
    @(negedge clk);
    in_data[3*IW +: IW] = IW'(42); in_valid[3] = 1'b1;
    rd_q[3].push_back(fbits(42));
    #1;
    exp_stalls++;
    checks++; if (proc_stall !== 1'b1) begin errors++; $display("FAIL empty_push_cycle got %b want 1", proc_stall); end
    @(negedge clk);
    in_valid[3] = 1'b0;
    #1;
    exp_f = rd_q[3].pop_front();
    checks++; if (proc_stall !== 1'b0 || proc_din !== exp_f) begin errors++; $display("FAIL empty_release got %b/%h want 0/%h", proc_stall, proc_din, exp_f); end
    @(negedge clk);
    proc_req_in = 1'b0;
  endtask

  task automatic test_backpressure();
    int exp_i;
    out_ready[0] = 1'b0;
    @(negedge clk);
    proc_out_en = 1'b1; proc_addr_out = 2'd0; proc_dout = fbits(100);
    out_q[0].push_back(100);
    #1;
    checks++; if (proc_stall !== 1'b0) begin errors++; $display("FAIL bp_first_write got %b want 0", proc_stall); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      proc_dout = fbits(200);
      #1;
      exp_stalls++;
      checks++; if (proc_stall !== 1'b1 || out_valid[0] !== 1'b1 || out_data[0 +: OW] !== OW'(out_q[0][0])) begin errors++; $display("FAIL bp_stall_%0d got s=%b v=%b d=%h want 1/1/%h", i, proc_stall, out_valid[0], out_data[0 +: OW], OW'(out_q[0][0])); end
    end
    // Consumer ready: old word transfers while the new one loads.
    @(negedge clk);
    out_ready[0] = 1'b1;
    #1;
    exp_i = out_q[0].pop_front();
    out_q[0].push_back(200);
    checks++; if (proc_stall !== 1'b0 || out_valid[0] !== 1'b1 || out_data[0 +: OW] !== OW'(exp_i)) begin errors++; $display("FAIL bp_release got s=%b v=%b d=%h want 0/1/%h", proc_stall, out_valid[0], out_data[0 +: OW], OW'(exp_i)); end
    @(negedge clk);
    proc_out_en = 1'b0;
    #1;
    exp_i = out_q[0].pop_front();
    checks++; if (out_valid[0] !== 1'b1 || out_data[0 +: OW] !== OW'(exp_i)) begin errors++; $display("FAIL bp_new_word got v=%b d=%h want 1/%h", out_valid[0], out_data[0 +: OW], OW'(exp_i)); end
    @(negedge clk);
    #1;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid[0]); end
  endtask

  task automatic test_addr_err();
    @(negedge clk);
    req3 = 1'b1; addr_in3 = 2'd3;
    #1;
    checks++; if (din3 !== '0 || stall3 !== 1'b0) begin errors++; $display("FAIL aerr_read got din=%h s=%b want 0/0", din3, stall3); end
    @(negedge clk);
    req3 = 1'b0;
    out_en3 = 1'b1; addr_out3 = 2'd3; dout3 = fbits(5);
    #1;
    checks++; if (addr_err3 !== 1'b1 || stall3 !== 1'b0) begin errors++; $display("FAIL aerr_set got e=%b s=%b want 1/0", addr_err3, stall3); end
    @(negedge clk);
    out_en3 = 1'b0;
    #1;
    checks++; if (out_valid3 !== 3'b000 || addr_err3 !== 1'b1) begin errors++; $display("FAIL aerr_sticky got v=%b e=%b want 000/1", out_valid3, addr_err3); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL aerr_main got %b want 0", addr_err); end
  endtask

  task automatic test_stats();
`ifdef PROC_IO_HUB_STATS_EN
    #1;
    checks++; if (stall_cnt !== 32'(exp_stalls)) begin errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_stalls); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] exp_f;
    @(negedge clk);
    in_data[2*IW +: IW] = IW'(9); in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    #2;
    rst = 1'b1;
    exp_stalls = 0;
    #1;
    checks++; if (addr_err3 !== 1'b0 || in_ready !== 4'hF || out_valid !== 4'h0) begin errors++; $display("FAIL mid_reset got e3=%b rdy=%b v=%b want 0/1111/0000", addr_err3, in_ready, out_valid); end
    @(negedge clk);
    rst = 1'b0;
    in_data[2*IW +: IW] = IW'(21); in_valid[2] = 1'b1;
    rd_q[2].push_back(fbits(21));
    proc_req_in = 1'b1; proc_addr_in = 2'd2;
    #1;
    exp_stalls++;
    checks++; if (proc_stall !== 1'b1 || proc_din !== '0) begin errors++; $display("FAIL mid_discard got %b/%h want 1/0", proc_stall, proc_din); end
    @(negedge clk);
    in_valid[2] = 1'b0;
    #1;
    exp_f = rd_q[2].pop_front();
    checks++; if (proc_stall !== 1'b0 || proc_din !== exp_f) begin errors++; $display("FAIL mid_first_push got %b/%h want 0/%h", proc_stall, proc_din, exp_f); end
    @(negedge clk);
    proc_req_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_fill();
    test_empty_stall();
    test_backpressure();
    test_addr_err();
    test_stats();
    test_reset_mid();
    test_stats();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
